// File: rtl/conv_filter_accumulator.sv
// Conv MAC sequencer: captures one multi-channel KxK window, pulls each (filter, channel)
// kernel from the weight ROM and emits one signed dot-product sum per filter.
module conv_filter_accumulator #(
  parameter int NUM_FILTERS    = 3,
  parameter int INPUT_CHANNELS = 3,
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int WEIGHT_WIDTH   = 16,
  parameter int ACC_WIDTH      = 40,
  localparam int T  = KERNEL_SIZE * KERNEL_SIZE,
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int CW = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [INPUT_CHANNELS*T*DATA_WIDTH-1:0] window_in,
  output logic                                   busy,
  output logic [FW-1:0]                          w_filter_idx,
  output logic [CW-1:0]                          w_channel_idx,
  output logic                                   w_read_enable,
  input  logic [T*WEIGHT_WIDTH-1:0]              w_flat,
  input  logic                                   w_valid,
  output logic [ACC_WIDTH-1:0]                   result,
  output logic [FW-1:0]                          result_filter_idx,
  output logic                                   result_valid,
  output logic                                   done
);

  localparam int TW = (T > 1) ? $clog2(T) : 1;
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int MW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_MAC, S_EMIT, S_FIN} state_t;

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   win_in_arr [INPUT_CHANNELS][T];
  logic signed [DATA_WIDTH-1:0]   win_q      [INPUT_CHANNELS][T];
  logic signed [DATA_WIDTH-1:0]   win_d      [INPUT_CHANNELS][T];
  logic signed [WEIGHT_WIDTH-1:0] kern_in_arr [T];
  logic signed [WEIGHT_WIDTH-1:0] kern_q      [T];
  logic signed [WEIGHT_WIDTH-1:0] kern_d      [T];
  logic [FW-1:0]                 f_q, f_d;
  logic [CW-1:0]                 c_q, c_d;
  logic [TW-1:0]                 tap_q, tap_d;
  logic                          wait_first_q, wait_first_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]   result_q, result_d;
  logic [FW-1:0]                 res_idx_q, res_idx_d;
  logic                          result_valid_q, result_valid_d;
  logic                          done_q, done_d;
  logic signed [MW-1:0]          a_ext, b_ext, prod;

  genvar gi, gj;
  generate
    for (gi = 0; gi < INPUT_CHANNELS; gi++) begin : g_win_ch
      for (gj = 0; gj < T; gj++) begin : g_win_tap
        assign win_in_arr[gi][gj] = window_in[(gi*T+gj+1)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
    for (gi = 0; gi < T; gi++) begin : g_kern_tap
      assign kern_in_arr[gi] = w_flat[(gi+1)*WEIGHT_WIDTH-1 -: WEIGHT_WIDTH];
    end
  endgenerate

  // Operands are sign-extended before multiplying so the full product survives; the
  // accumulator then wraps naturally at ACC_WIDTH.
  always_comb begin
    a_ext = MW'(win_q[c_q][tap_q]);
    b_ext = MW'(kern_q[tap_q]);
    prod  = a_ext * b_ext;
  end

  always_comb begin
    state_d        = state_q;
    win_d          = win_q;
    kern_d         = kern_q;
    f_d            = f_q;
    c_d            = c_q;
    tap_d          = tap_q;
    wait_first_d   = wait_first_q;
    acc_d          = acc_q;
    result_d       = result_q;
    res_idx_d      = res_idx_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d   = win_in_arr;
          f_d     = '0;
          c_d     = '0;
          tap_d   = '0;
          acc_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        wait_first_d = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // The ROM may still be showing valid from the previous read on the first cycle.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (w_valid) begin
          kern_d  = kern_in_arr;
          tap_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod[ACC_WIDTH-1:0];
        if (tap_q == TW'(T - 1)) begin
          tap_d = '0;
          if (c_q == CW'(INPUT_CHANNELS - 1)) begin
            state_d = S_EMIT;
          end else begin
            c_d     = c_q + CW'(1);
            state_d = S_REQ;
          end
        end else begin
          tap_d = tap_q + TW'(1);
        end
      end
      S_EMIT: begin
        result_d       = acc_q;
        res_idx_d      = f_q;
        result_valid_d = 1'b1;
        acc_d          = '0;
        c_d            = '0;
        if (f_q == FW'(NUM_FILTERS - 1)) begin
          state_d = S_FIN;
        end else begin
          f_d     = f_q + FW'(1);
          state_d = S_REQ;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      for (int c = 0; c < INPUT_CHANNELS; c++) begin
        for (int i = 0; i < T; i++) begin
          win_q[c][i] <= '0;
        end
      end
      for (int i = 0; i < T; i++) begin
        kern_q[i] <= '0;
      end
      f_q            <= '0;
      c_q            <= '0;
      tap_q          <= '0;
      wait_first_q   <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      res_idx_q      <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      win_q          <= win_d;
      kern_q         <= kern_d;
      f_q            <= f_d;
      c_q            <= c_d;
      tap_q          <= tap_d;
      wait_first_q   <= wait_first_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      res_idx_q      <= res_idx_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign w_read_enable     = (state_q == S_REQ);
  assign w_filter_idx      = f_q;
  assign w_channel_idx     = c_q;
  assign result            = result_q;
  assign result_filter_idx = res_idx_q;
  assign result_valid      = result_valid_q;
  assign done              = done_q;

endmodule

// File: tb/tb_conv_filter_accumulator.sv
// Directed bench for conv_filter_accumulator: ROM responder model, scoreboard of
// per-filter sums, timing/read-order checks and a mid-job reset.
module tb_conv_filter_accumulator;

  localparam int NF = 3;
  localparam int IC = 3;
  localparam int K  = 3;
  localparam int T  = K * K;
  localparam int DW = 16;
  localparam int WW = 16;
  localparam int AW = 40;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [IC*T*DW-1:0]   window_in = '0;
  logic                 busy;
  logic [1:0]           w_filter_idx;
  logic [1:0]           w_channel_idx;
  logic                 w_read_enable;
  logic [T*WW-1:0]      w_flat = '0;
  logic                 w_valid = 1'b0;
  logic [AW-1:0]        result;
  logic [1:0]           result_filter_idx;
  logic                 result_valid;
  logic                 done;

  conv_filter_accumulator #(
    .NUM_FILTERS(NF), .INPUT_CHANNELS(IC), .KERNEL_SIZE(K),
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .window_in(window_in), .busy(busy),
    .w_filter_idx(w_filter_idx), .w_channel_idx(w_channel_idx),
    .w_read_enable(w_read_enable), .w_flat(w_flat), .w_valid(w_valid),
    .result(result), .result_filter_idx(result_filter_idx),
    .result_valid(result_valid), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         idx;
    logic signed [63:0] val;
  } exp_t;

  logic signed [DW-1:0] win_v [IC][T];
  logic signed [WW-1:0] wt    [NF][IC][T];
  exp_t                 sb [$];
  logic [3:0]           rd_log [$];
  int                   rom_delay = 8;
  logic                 rom_busy = 1'b0;
  int                   rom_cnt = 0;
  int                   rom_f = 0;
  int                   rom_c = 0;
  int                   checks = 0;
  int                   passes = 0;

  function automatic logic [T*WW-1:0] pack_kern(input int f, input int c);
    logic [T*WW-1:0] r;
    r = '0;
    for (int i = 0; i < T; i++) r[i*WW +: WW] = wt[f][c][i];
    return r;
  endfunction

  // ROM responder: valid stays high from the previous read until the cycle after the
  // next request, then rises again rom_delay cycles later (WAIT length = rom_delay + 2).
  always @(posedge clk) begin
    if (w_read_enable) begin
      rom_busy <= 1'b1;
      rom_cnt  <= 0;
      rom_f    <= int'(w_filter_idx);
      rom_c    <= int'(w_channel_idx);
      rd_log.push_back({w_filter_idx, w_channel_idx});
    end else if (rom_busy) begin
      rom_cnt <= rom_cnt + 1;
      w_valid <= 1'b0;
      if (rom_cnt == rom_delay) begin
        w_valid  <= 1'b1;
        w_flat   <= pack_kern(rom_f, rom_c);
        rom_busy <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic signed [63:0] model_sum(input int f);
    longint s;
    logic signed [AW-1:0] w;
    s = 0;
    for (int c = 0; c < IC; c++)
      for (int i = 0; i < T; i++)
        s += longint'(win_v[c][i]) * longint'(wt[f][c][i]);
    w = s[AW-1:0];
    return w;
  endfunction

  task automatic load_window();
    for (int c = 0; c < IC; c++)
      for (int i = 0; i < T; i++)
        window_in[(c*T+i)*DW +: DW] = win_v[c][i];
  endtask

  task automatic fill(input logic signed [DW-1:0] wv, input int wmode,
                      input logic signed [WW-1:0] wconst);
    for (int c = 0; c < IC; c++)
      for (int i = 0; i < T; i++) begin
        win_v[c][i] = wv;
        for (int f = 0; f < NF; f++)
          wt[f][c][i] = (wmode == 1) ? WW'(f + 1) : wconst;
      end
  endtask

  task automatic run_job(input string name, input bit glitch);
    int   per, cyc, last, npulse;
    bit   got_done;
    exp_t e;
    logic [3:0] exp_rd;
    per = IC * (1 + (rom_delay + 2) + T) + 1;
    last = 0; npulse = 0; got_done = 0;
    sb.delete();
    rd_log.delete();
    for (int f = 0; f < NF; f++) begin
      e.idx = 2'(f);
      e.val = model_sum(f);
      sb.push_back(e);
    end
    @(negedge clk);
    load_window();
    start = 1'b1;
    for (cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd1);
      end
      if (glitch && cyc == 30) begin
        start = 1'b1;
        window_in = '1;
      end
      if (glitch && cyc == 31) start = 1'b0;
      if (result_valid) begin
        if (sb.size() == 0) begin
          check({name, "_extra_result"}, 64'(npulse), 64'(NF));
        end else begin
          e = sb.pop_front();
          $display("%s: result filter %0d = %0d", name, result_filter_idx, $signed(result));
          check({name, "_idx"}, 64'(result_filter_idx), 64'(e.idx));
          check({name, "_result"}, $signed(result), e.val);
          if (npulse == 0) check({name, "_latency"}, 64'(cyc), 64'(per + 1));
          else             check({name, "_spacing"}, 64'(cyc - last), 64'(per));
        end
        last = cyc;
        npulse++;
      end
      if (done) begin
        check({name, "_done_timing"}, 64'(cyc), 64'(last + 1));
        check({name, "_npulse"}, 64'(npulse), 64'(NF));
        check({name, "_idle_at_done"}, 64'(busy), 64'd0);
        got_done = 1;
        break;
      end
    end
    if (!got_done) check({name, "_timeout"}, 64'd0, 64'd1);
    check({name, "_reads"}, 64'(rd_log.size()), 64'(NF * IC));
    for (int k = 0; k < NF * IC && k < rd_log.size(); k++) begin
      exp_rd = {2'(k / IC), 2'(k % IC)};
      check({name, "_read_order"}, 64'(rd_log[k]), 64'(exp_rd));
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_rd_en"}, 64'(w_read_enable), 64'd0);
    check({name, "_fidx"}, 64'(w_filter_idx), 64'd0);
    check({name, "_cidx"}, 64'(w_channel_idx), 64'd0);
    check({name, "_result"}, 64'(result), 64'd0);
    check({name, "_ridx"}, 64'(result_filter_idx), 64'd0);
    check({name, "_rvalid"}, 64'(result_valid), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fill(16'sd1, 0, 16'sd1);
    rom_delay = 8;
    run_job("t1_ones", 1'b0);

    fill(-16'sd1, 1, 16'sd0);
    run_job("t2_neg", 1'b0);

    fill(16'sh8000, 0, 16'sh8000);
    run_job("t3_minval", 1'b0);
    check("t3_model", model_sum(0), 64'sd28991029248);

    fill(16'sd1, 0, 16'sd1);
    rom_delay = 28;
    run_job("t4_slow_rom", 1'b0);

    fill(-16'sd1, 1, 16'sd0);
    rom_delay = 8;
    run_job("t5_glitch", 1'b1);

    // Abort during MAC of filter 1.
    fill(16'sd1, 0, 16'sd1);
    rd_log.delete();
    @(negedge clk);
    load_window();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 1000 && rd_log.size() < 4; n++) @(negedge clk);
    check("t6_reach_f1", 64'(rd_log.size() >= 4), 64'd1);
    repeat (rom_delay + 2 + 3) @(negedge clk);
    check("t6_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    @(negedge clk);
    check_outputs_zero("t6_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (result_valid || done || busy) pulses++;
    end
    check("t6_no_activity", 64'(pulses), 64'd0);
    run_job("t6_clean", 1'b0);

    for (int c = 0; c < IC; c++)
      for (int i = 0; i < T; i++) begin
        win_v[c][i] = DW'($urandom);
        for (int f = 0; f < NF; f++) wt[f][c][i] = WW'($urandom);
      end
    rom_delay = 0;
    run_job("t7_random", 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
